// File: rtl/gate_reduce_pipe_pkg.sv
// Shared constants for the gate reduction pipeline: reduction mode encodings
// and the width of the optional output beat counter.
package gate_reduce_pipe_pkg;

  localparam logic [1:0] MODE_NAND = 2'b00;
  localparam logic [1:0] MODE_NOR  = 2'b01;
  localparam logic [1:0] MODE_AND  = 2'b10;
  localparam logic [1:0] MODE_OR   = 2'b11;

  localparam int GATE_PIPE_CNT_W = 16;

endpackage

// File: rtl/gate_reduce_pipe_stage.sv
// One valid/ready register slot of the gate reduction pipeline, carrying the
// per-channel result bits and the mode that produced them.
module gate_pipe_stage #(
  parameter int CHANNELS = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                up_valid,
  output logic                up_ready,
  input  logic [CHANNELS-1:0] up_data,
  input  logic [1:0]          up_mode,
  output logic                dn_valid,
  input  logic                dn_ready,
  output logic [CHANNELS-1:0] dn_data,
  output logic [1:0]          dn_mode
);

  logic                valid_q, valid_d;
  logic [CHANNELS-1:0] data_q, data_d;
  logic [1:0]          mode_q, mode_d;

  // The slot can take a new beat when empty or when its contents leave this cycle.
  assign up_ready = !valid_q || dn_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    mode_d  = mode_q;
    if (up_ready) begin
      valid_d = up_valid;
      if (up_valid) begin
        data_d = up_data;
        mode_d = up_mode;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      mode_q  <= 2'b00;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
    end
  end

  assign dn_valid = valid_q;
  assign dn_data  = data_q;
  assign dn_mode  = mode_q;

endmodule

// File: rtl/gate_reduce_pipe.sv
// Reduces CHANNELS WIDTH-bit lanes to one bit each (NAND/NOR/AND/OR per beat)
// and carries the result through a STAGES-deep valid/ready pipeline.
// Define GATE_PIPE_CNT_EN to add the out_count popped-beat counter.
module gate_reduce_pipe
  import gate_reduce_pipe_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 2,
  parameter int STAGES   = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [1:0]                in_mode,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS-1:0]       out_data,
  output logic [1:0]                out_mode
`ifdef GATE_PIPE_CNT_EN
  ,
  output logic [GATE_PIPE_CNT_W-1:0] out_count
`endif
);

  // Handshake: a beat transfers on a rising edge where valid && ready are both
  // high; a stage with a beat holds it unchanged until its downstream is ready.

  function automatic logic reduce_bits(input logic [WIDTH-1:0] v, input logic [1:0] mode);
    logic r;
    case (mode)
      MODE_NAND: r = ~&v;
      MODE_NOR:  r = ~|v;
      MODE_AND:  r = &v;
      default:   r = |v;
    endcase
    return r;
  endfunction

  logic [CHANNELS*WIDTH-1:0] gated_data;
  logic [1:0]                gated_mode;
  logic [CHANNELS-1:0]       red_data;

  // Idle inputs are forced to zero so undriven buses never reach the gates.
  always_comb begin
    gated_data = in_valid ? in_data : '0;
    gated_mode = in_valid ? in_mode : MODE_NAND;
    red_data   = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      red_data[c] = reduce_bits(gated_data[c*WIDTH +: WIDTH], gated_mode);
    end
  end

  logic                stg_valid [STAGES+1];
  logic                stg_ready [STAGES+1];
  logic [CHANNELS-1:0] stg_data  [STAGES+1];
  logic [1:0]          stg_mode  [STAGES+1];

  assign stg_valid[0]      = in_valid;
  assign stg_data[0]       = red_data;
  assign stg_mode[0]       = gated_mode;
  assign stg_ready[STAGES] = out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    gate_pipe_stage #(
      .CHANNELS(CHANNELS)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .up_valid (stg_valid[k]),
      .up_ready (stg_ready[k]),
      .up_data  (stg_data[k]),
      .up_mode  (stg_mode[k]),
      .dn_valid (stg_valid[k+1]),
      .dn_ready (stg_ready[k+1]),
      .dn_data  (stg_data[k+1]),
      .dn_mode  (stg_mode[k+1])
    );
  end

  assign in_ready  = stg_ready[0];
  assign out_valid = stg_valid[STAGES];
  assign out_data  = stg_data[STAGES];
  assign out_mode  = stg_mode[STAGES];

`ifdef GATE_PIPE_CNT_EN
  logic [GATE_PIPE_CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (out_valid && out_ready) begin
      count_d = count_q + GATE_PIPE_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign out_count = count_q;
`endif

endmodule

// File: tb/tb_gate_reduce_pipe.sv
// Self-checking bench for gate_reduce_pipe (default parameters); exercises the
// out_count port when GATE_PIPE_CNT_EN is defined.
module tb_gate_reduce_pipe;

  localparam int WIDTH    = 4;
  localparam int CHANNELS = 2;
  localparam int STAGES   = 2;
  localparam int DW       = CHANNELS * WIDTH;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [DW-1:0]   in_data = '0;
  logic [1:0]      in_mode = 2'b00;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [CHANNELS-1:0] out_data;
  logic [1:0]      out_mode;
`ifdef GATE_PIPE_CNT_EN
  logic [15:0]     out_count;
  logic [15:0]     cnt_model = '0;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pops = 0;
  int first_pop = 0;
  int last_pop = 0;

  logic [CHANNELS+1:0] exp_q[$];

  gate_reduce_pipe #(
    .WIDTH(WIDTH), .CHANNELS(CHANNELS), .STAGES(STAGES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_mode  (out_mode)
`ifdef GATE_PIPE_CNT_EN
    ,
    .out_count (out_count)
`endif
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  // Model: each lane is all-ones / any-one tested against the selected gate.
  function automatic logic [CHANNELS+1:0] model(input logic [DW-1:0] d, input logic [1:0] m);
    logic [CHANNELS-1:0] r;
    int lane;
    bit all1, any1;
    r = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      lane = int'((d >> (c * WIDTH)) & ((1 << WIDTH) - 1));
      all1 = (lane == (1 << WIDTH) - 1);
      any1 = (lane != 0);
      case (m)
        2'd0: r[c] = !all1;
        2'd1: r[c] = !any1;
        2'd2: r[c] = all1;
        default: r[c] = any1;
      endcase
    end
    return {m, r};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 'h%0h want 'h%0h at cycle %0d", name, got, want, cyc);
    end
  endtask

  // scoreboard / compare process
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
`ifdef GATE_PIPE_CNT_EN
      cnt_model = '0;
`endif
    end else begin
      check("in_ready", 32'(in_ready), 32'((exp_q.size() < STAGES) || out_ready));
`ifdef GATE_PIPE_CNT_EN
      check("out_count", 32'(out_count), 32'(cnt_model));
`endif
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_out: got out_valid=1 data 'h%0h want no beat at cycle %0d", out_data, cyc);
        end else begin
          check("out_beat", 32'({out_mode, out_data}), 32'(exp_q[0]));
          if (out_ready) begin
            void'(exp_q.pop_front());
            if (pops == 0) first_pop = cyc;
            last_pop = cyc;
            pops++;
`ifdef GATE_PIPE_CNT_EN
            cnt_model = cnt_model + 16'd1;
`endif
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_data, in_mode));
    end
  end

  // driver tasks (called at posedge + #1)
  task automatic send(input logic [DW-1:0] d, input logic [1:0] m);
    int guard;
    guard = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 for 50 cycles want 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] tt_data;
  logic [1:0]    tt_want [4];

  initial begin
    // 1. reset with a beat presented
    in_valid = 1'b1;
    in_data  = 8'hA5;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_mode", 32'(out_mode), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = '0;
    rst_n    = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // 2. truth table on 8'hF0, latency pinned by literal expectations
    tt_data = 8'hF0;
    tt_want[0] = 2'b01;
    tt_want[1] = 2'b01;
    tt_want[2] = 2'b10;
    tt_want[3] = 2'b10;
    for (int m = 0; m < 4; m++) begin
      send(tt_data, 2'(m));
      @(negedge clk);
      check("tt_lat_early", 32'(out_valid), 32'd0);
      @(negedge clk);
      check("tt_lat_valid", 32'(out_valid), 32'd1);
      check("tt_data", 32'(out_data), 32'(tt_want[m]));
      check("tt_mode", 32'(out_mode), 32'(m));
      @(posedge clk);
      #1;
    end

    // 3. backpressure: two beats fill the pipe, third must wait
    out_ready = 1'b0;
    send(8'h0F, 2'b10);
    send(8'h3C, 2'b11);
    in_valid = 1'b1;
    in_data  = 8'hFF;
    in_mode  = 2'b00;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_hold", 32'({out_valid, out_mode, out_data}), 32'({1'b1, 2'b10, 2'b01}));
    end
    @(posedge clk);
    #1;
    pops = 0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = '0;
    idle(5);
    check("bp_pops", 32'(pops), 32'd3);

    // 4. streaming 16 mixed-mode beats
    pops = 0;
    for (int i = 0; i < 16; i++) begin
      send(8'(i * 8'h1D + 8'h07), 2'(i % 4));
    end
    idle(5);
    check("stream_pops", 32'(pops), 32'd16);
    check("stream_span", 32'(last_pop - first_pop), 32'd15);
    check("stream_drained", 32'(exp_q.size()), 32'd0);

    // 5. reset with two beats in flight
    send(8'h12, 2'b11);
    send(8'h34, 2'b01);
    rst_n = 1'b0;
    #1;
    check("midrst_flush", 32'(out_valid), 32'd0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("midrst_stale", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;

`ifdef GATE_PIPE_CNT_EN
    // 6. counter wrap and stall behaviour
    for (int i = 0; i < 65537; i++) begin
      send(8'(i), 2'(i % 4));
    end
    idle(5);
    check("cnt_wrap", 32'(out_count), 32'd1);
    out_ready = 1'b0;
    send(8'h55, 2'b10);
    idle(6);
    check("cnt_stall", 32'(out_count), 32'd1);
    out_ready = 1'b1;
    idle(4);
    check("cnt_after_stall", 32'(out_count), 32'd2);
`endif

    check("final_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
